// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: mux-select encodings,
// observability state codes and the per-stage register tags.
package hazard_pkg;

  localparam int unsigned TAG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b10,
    FWD_MEMWB = 2'b01
  } fwd_e;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_FLUSH    = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;
    logic              uses_rs2;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              alusrc;
  } stage_tag_t;

  // Past EX only the destination matters for forwarding; a bubble has regwrite=0.
  typedef struct packed {
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
  } fwd_tag_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned AW = TAG_AW
) (
  input  logic [AW-1:0] src_idx,
  input  logic          src_used,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regwrite,
  output fwd_e          sel
);

  always_comb begin
    sel = FWD_REG;
    if (src_used && mem_regwrite && (mem_rd != '0) && (mem_rd == src_idx)) begin
      sel = FWD_EXMEM;
    end else if (src_used && wb_regwrite && (wb_rd != '0) && (wb_rd == src_idx)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding control.
// Optional HAZARD_PERF_EN adds saturating STALL_CNT/FLUSH_CNT outputs.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = TAG_AW,
  parameter int unsigned PERF_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic              ID_USES_RS2,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_REGWRITE,
  input  logic              ID_MEMREAD,
  input  logic              ID_ALUSRC,
  input  logic              BRANCH_TAKEN,
  output logic [1:0]        FORWARD_A,
  output logic [1:0]        FORWARD_B,
  output logic              ALUSRC_EX,
  output logic              PC_WRITE,
  output logic              IFID_WRITE,
  output logic              IFID_FLUSH,
  output logic              IDEX_BUBBLE,
  output logic [1:0]        HZ_STATE
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] STALL_CNT,
  output logic [PERF_W-1:0] FLUSH_CNT
`endif
);

  stage_tag_t id_tag, ex_d, ex_q;
  fwd_tag_t   mem_d, mem_q, wb_d, wb_q;
  hz_state_e  state_d, state_q;
  fwd_e       fwd_a, fwd_b;
  logic       branch, lu, stall, bubble;

  always_comb begin
    id_tag = '{valid: ID_VALID, rs1: ID_RS1, rs2: ID_RS2, uses_rs2: ID_USES_RS2,
               rd: ID_RD, regwrite: ID_REGWRITE, memread: ID_MEMREAD, alusrc: ID_ALUSRC};
    // Branch is masked during reset so the flush/bubble outputs hold their reset values.
    branch = BRANCH_TAKEN & RST_N;
    lu     = ID_VALID & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
             ((ex_q.rd == ID_RS1) | (ID_USES_RS2 & (ex_q.rd == ID_RS2)));
    stall  = lu & ~branch;
    bubble = branch | lu;
    ex_d   = (bubble || !ID_VALID) ? '0 : id_tag;
    mem_d  = '{rd: ex_q.rd, regwrite: ex_q.regwrite};
    wb_d   = mem_q;
    state_d = HZ_RUN;
    if (branch)  state_d = HZ_FLUSH;
    else if (lu) state_d = HZ_LU_STALL;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= HZ_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

  fwd_sel #(.AW(TAG_AW)) u_fwd_a (
    .src_idx      (ex_q.rs1),
    .src_used     (1'b1),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (fwd_a)
  );

  fwd_sel #(.AW(TAG_AW)) u_fwd_b (
    .src_idx      (ex_q.rs2),
    .src_used     (ex_q.uses_rs2),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (fwd_b)
  );

  assign FORWARD_A   = fwd_a;
  assign FORWARD_B   = fwd_b;
  assign ALUSRC_EX   = ex_q.alusrc;
  assign PC_WRITE    = ~stall;
  assign IFID_WRITE  = ~stall;
  assign IFID_FLUSH  = branch;
  assign IDEX_BUBBLE = bubble;
  assign HZ_STATE    = state_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus random stream
// against an instruction-level pipeline model.
module tb_hazard_fwd_ctrl;

  localparam int PW = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       ID_VALID = 1'b0;
  logic [4:0] ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
  logic       ID_USES_RS2 = 1'b0, ID_REGWRITE = 1'b0, ID_MEMREAD = 1'b0, ID_ALUSRC = 1'b0;
  logic       BRANCH_TAKEN = 1'b0;
  logic [1:0] FORWARD_A, FORWARD_B, HZ_STATE;
  logic       ALUSRC_EX, PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE;
`ifdef HAZARD_PERF_EN
  logic [PW-1:0] STALL_CNT, FLUSH_CNT;
`endif

  hazard_fwd_ctrl #(.REG_AW(5), .PERF_W(PW)) dut (
    .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS2(ID_USES_RS2), .ID_RD(ID_RD), .ID_REGWRITE(ID_REGWRITE),
    .ID_MEMREAD(ID_MEMREAD), .ID_ALUSRC(ID_ALUSRC), .BRANCH_TAKEN(BRANCH_TAKEN),
    .FORWARD_A(FORWARD_A), .FORWARD_B(FORWARD_B), .ALUSRC_EX(ALUSRC_EX),
    .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .IFID_FLUSH(IFID_FLUSH),
    .IDEX_BUBBLE(IDEX_BUBBLE), .HZ_STATE(HZ_STATE)
`ifdef HAZARD_PERF_EN
    , .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit valid; int rs1; int rs2; bit uses2; int rd; bit rw; bit mr; bit as;
  } ins_t;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB (what actually entered each stage).
  ins_t pipe[3];
  ins_t cur;
  bit   cur_br, m_lu;
  int   st_prev, stalls, flushes;
  int   n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit v, int rs1, int rs2, bit u2, int rd, bit rw, bit mr, bit as);
    ins_t i;
    i.valid = v; i.rs1 = rs1; i.rs2 = rs2; i.uses2 = u2;
    i.rd = rd; i.rw = rw; i.mr = mr; i.as = as;
    return i;
  endfunction

  function automatic ins_t nop_ins();
    ins_t z;
    z = '{default: 0};
    return z;
  endfunction

  // Youngest older producer wins; x0 and non-writers never supply a value.
  function automatic int fwd_exp(int src, bit used);
    if (!used) return 0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src)
        return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = nop_ins();
    st_prev = 0; stalls = 0; flushes = 0;
  endtask

  task automatic compare();
    ins_t ex;
    bit stall;
    ex = pipe[0];
    m_lu = cur.valid && ex.valid && ex.mr && ex.rd != 0 &&
           (ex.rd == cur.rs1 || (cur.uses2 && ex.rd == cur.rs2));
    stall = m_lu && !cur_br;
    check("pc_write",    {31'b0, PC_WRITE},    {31'b0, !stall});
    check("ifid_write",  {31'b0, IFID_WRITE},  {31'b0, !stall});
    check("ifid_flush",  {31'b0, IFID_FLUSH},  {31'b0, cur_br});
    check("idex_bubble", {31'b0, IDEX_BUBBLE}, {31'b0, cur_br || m_lu});
    check("forward_a",   {30'b0, FORWARD_A},   fwd_exp(ex.rs1, 1'b1));
    check("forward_b",   {30'b0, FORWARD_B},   fwd_exp(ex.rs2, ex.uses2));
    check("alusrc_ex",   {31'b0, ALUSRC_EX},   {31'b0, ex.as});
    check("hz_state",    {30'b0, HZ_STATE},    st_prev);
`ifdef HAZARD_PERF_EN
    check("stall_cnt", {{(32-PW){1'b0}}, STALL_CNT}, stalls);
    check("flush_cnt", {{(32-PW){1'b0}}, FLUSH_CNT}, flushes);
`endif
  endtask

  task automatic drive(input ins_t i, input bit br);
    @(negedge CLK);
    ID_VALID = i.valid; ID_RS1 = 5'(i.rs1); ID_RS2 = 5'(i.rs2); ID_USES_RS2 = i.uses2;
    ID_RD = 5'(i.rd); ID_REGWRITE = i.rw; ID_MEMREAD = i.mr; ID_ALUSRC = i.as;
    BRANCH_TAKEN = br;
    cur = i; cur_br = br;
    #1 compare();
  endtask

  task automatic adv();
    @(posedge CLK);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (cur_br || m_lu || !cur.valid) ? nop_ins() : cur;
    st_prev = cur_br ? 2 : (m_lu ? 1 : 0);
    if (m_lu && !cur_br && stalls < (1 << PW) - 1) stalls++;
    if (cur_br && flushes < (1 << PW) - 1) flushes++;
  endtask

  task automatic step(input ins_t i, input bit br);
    drive(i, br);
    adv();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    ID_VALID = 1'b1; ID_RS1 = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1;
    ID_RD = 5'd5; ID_REGWRITE = 1'b1; ID_MEMREAD = 1'b1; BRANCH_TAKEN = 1'b1;
    #1;
    check("rst_fwd_a",  {30'b0, FORWARD_A},   0);
    check("rst_fwd_b",  {30'b0, FORWARD_B},   0);
    check("rst_alusrc", {31'b0, ALUSRC_EX},   0);
    check("rst_pc",     {31'b0, PC_WRITE},    1);
    check("rst_ifidw",  {31'b0, IFID_WRITE},  1);
    check("rst_flush",  {31'b0, IFID_FLUSH},  0);
    check("rst_bubble", {31'b0, IDEX_BUBBLE}, 0);
    check("rst_state",  {30'b0, HZ_STATE},    0);
`ifdef HAZARD_PERF_EN
    check("rst_stall_cnt", {{(32-PW){1'b0}}, STALL_CNT}, 0);
    check("rst_flush_cnt", {{(32-PW){1'b0}}, FLUSH_CNT}, 0);
`endif
    @(posedge CLK);
    @(negedge CLK);
    BRANCH_TAKEN = 1'b0; ID_VALID = 1'b0;
    RST_N = 1'b1;
    model_reset();
  endtask

  ins_t lw5, use5, filler;

  initial begin
    model_reset();
    do_reset();

    // After release: addi x5,x1,4 reaches EX next cycle.
    step(mk(1, 1, 0, 0, 5, 1, 0, 1), 0);
    drive(mk(1, 11, 12, 1, 10, 1, 0, 0), 0);            // or x10,x11,x12
    check("first_in_ex_alusrc", {31'b0, ALUSRC_EX}, 1);
    adv();
    drive(mk(1, 5, 7, 1, 6, 1, 0, 0), 0);               // sub x6,x5,x7
    adv();
    drive(mk(1, 6, 0, 1, 8, 1, 0, 0), 0);               // and x8,x6,x0 (sub in EX, addi in WB)
    check("gap_fwd_a", {30'b0, FORWARD_A}, 2'b01);
    adv();
    drive(mk(1, 20, 21, 1, 22, 1, 0, 0), 0);            // and in EX, sub in MEM
    check("b2b_fwd_a", {30'b0, FORWARD_A}, 2'b10);
    adv();

    // Double producer of x5, then x0 producer.
    step(mk(1, 1, 2, 1, 5, 1, 0, 0), 0);
    step(mk(1, 3, 4, 1, 5, 1, 0, 0), 0);
    step(mk(1, 5, 9, 1, 11, 1, 0, 0), 0);
    drive(mk(1, 1, 2, 1, 0, 1, 0, 0), 0);               // add x0,x1,x2
    check("mem_wins_fwd_a", {30'b0, FORWARD_A}, 2'b10);
    adv();
    step(mk(1, 0, 0, 1, 12, 1, 0, 0), 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    check("x0_no_fwd_a", {30'b0, FORWARD_A}, 2'b00);
    adv();

    // Load-use x3: lw x5 then add x8,x5,x9, held in ID across the stall.
    lw5  = mk(1, 1, 0, 0, 5, 1, 1, 1);
    use5 = mk(1, 5, 9, 1, 8, 1, 0, 0);
    filler = mk(1, 14, 15, 1, 16, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(lw5, 0);
      drive(use5, 0);
      check("lu_pc_write",   {31'b0, PC_WRITE},    0);
      check("lu_ifid_write", {31'b0, IFID_WRITE},  0);
      check("lu_bubble",     {31'b0, IDEX_BUBBLE}, 1);
      adv();
      drive(use5, 0);
      check("lu_state", {30'b0, HZ_STATE}, 2'b01);
      check("lu_clear", {31'b0, PC_WRITE}, 1);
      adv();
      drive(filler, 0);
      check("lu_fwd_a", {30'b0, FORWARD_A}, 2'b01);
      adv();
    end

    // Branch together with a load-use.
    step(lw5, 0);
    drive(use5, 1);
    check("br_flush",  {31'b0, IFID_FLUSH},  1);
    check("br_bubble", {31'b0, IDEX_BUBBLE}, 1);
    check("br_pc",     {31'b0, PC_WRITE},    1);
    adv();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    check("br_state", {30'b0, HZ_STATE}, 2'b10);
    adv();

    // ALUSrc: addi x3,x1,4 whose rs2 field equals MEM.rd.
    step(mk(1, 20, 21, 1, 7, 1, 0, 0), 0);
    step(mk(1, 1, 7, 0, 3, 1, 0, 1), 1'b0);
    drive(mk(1, 22, 23, 1, 24, 1, 0, 0), 1);
    check("addi_alusrc", {31'b0, ALUSRC_EX}, 1);
    check("addi_fwd_b",  {30'b0, FORWARD_B}, 2'b00);
    adv();
`ifdef HAZARD_PERF_EN
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    check("perf_stalls",  {{(32-PW){1'b0}}, STALL_CNT}, 3);
    check("perf_flushes", {{(32-PW){1'b0}}, FLUSH_CNT}, 2);
    adv();
`endif

    // Random stream with a narrow register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      ins_t r;
      if (i == 300) do_reset();
      r = mk($urandom_range(7, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0) != 0,
             $urandom_range(2, 0) == 0, $urandom_range(1, 0));
      step(r, $urandom_range(7, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline hazard and operand-select controller for the 5-stage core.
- Keeps its own copy of the register tags for the EX, MEM and WB stages.
- Drives the ForwardA/ForwardB mux selects and the registered ALUSrc select into EX.
- Detects load-use hazards and inserts a one-cycle bubble.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Sits beside the ID/EX register and steers the EX-stage operand muxes.

Parameters:
REG_AW, 5, register-index width
PERF_W, 16, width of the optional performance counters

Ports:
CLK  in  1  core clock
RST_N  in  1  asynchronous active-low reset
ID_VALID  in  1  ID stage holds a real instruction
ID_RS1  in  REG_AW  source register 1 index
ID_RS2  in  REG_AW  source register 2 index
ID_USES_RS2  in  1  instruction reads RS2 (R-type, branch, store)
ID_RD  in  REG_AW  destination index
ID_REGWRITE  in  1  instruction writes RD
ID_MEMREAD  in  1  instruction is a load
ID_ALUSRC  in  1  ALU B operand is the immediate
BRANCH_TAKEN  in  1  EX resolved a taken branch this cycle
FORWARD_A  out  2  00 = register file, 10 = EX/MEM, 01 = MEM/WB
FORWARD_B  out  2  same encoding
ALUSRC_EX  out  1  ALUSrc for the instruction currently in EX
PC_WRITE  out  1  PC enable
IFID_WRITE  out  1  IF/ID enable
IFID_FLUSH  out  1  zero IF/ID
IDEX_BUBBLE  out  1  load a NOP into ID/EX
HZ_STATE  out  2  00 RUN, 01 LU_STALL, 10 FLUSH

Behaviour:
- Reset (async, RST_N=0):
  - All stage tags are cleared to valid=0, rd=0, regwrite=0, memread=0, alusrc=0.
  - Outputs during and after reset: FORWARD_A/B=00, ALUSRC_EX=0, PC_WRITE=1, IFID_WRITE=1, IFID_FLUSH=0, IDEX_BUBBLE=0, HZ_STATE=RUN.
- Stage tag advance, every rising CLK:
  - WB <= MEM, MEM <= EX.
  - EX <= ID inputs, except EX <= bubble (all-zero tags) when IDEX_BUBBLE=1 or ID_VALID=0.
- Load-use detection (combinational):
  - lu = ID_VALID & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==ID_RS1 | (ID_USES_RS2 & EX.rd==ID_RS2)).
- Branch flush:
  - BRANCH_TAKEN=1 gives IFID_FLUSH=1 and IDEX_BUBBLE=1 in the same cycle.
  - PC_WRITE stays 1 so the target is fetched.
  - Branch wins over lu: no stall is asserted in that cycle.
- Load-use stall, when lu=1 and no branch:
  - PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1 for exactly one cycle.
  - The next cycle the load sits in MEM and EX holds a bubble, so lu clears by construction.
- FSM, next state decided each cycle:
  - Next state is FLUSH if BRANCH_TAKEN, else LU_STALL if lu, else RUN.
  - HZ_STATE shows the state registered from the previous cycle's decision. It is for observability only; the control outputs come from the current-cycle conditions above.
- Forwarding (combinational from the EX/MEM/WB tags), FORWARD_A:
  - 10 if MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1.
  - Otherwise 01 if WB.regwrite & WB.rd!=0 & WB.rd==EX.rs1.
  - Otherwise 00.
  - FORWARD_B uses the same rules on EX.rs2, gated by EX.uses_rs2.
  - MEM has priority over WB when both match.
  - Register x0 never forwards.
  - Bubble tags never match, because regwrite=0.
- ALUSRC_EX = EX.alusrc. It is 0 for a bubble.
- Reset mid-stall or mid-flush returns immediately to the reset values listed above.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds outputs STALL_CNT[PERF_W] and FLUSH_CNT[PERF_W], reset to 0.
  - STALL_CNT increments on each load-use stall cycle; FLUSH_CNT increments on each BRANCH_TAKEN cycle.
  - Both counters saturate at all-ones.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REG/FWD_EXMEM/FWD_MEMWB encodings.
  - HZ_RUN/HZ_LU_STALL/HZ_FLUSH state codes.
  - The stage-tag struct (valid, rs1, rs2, uses_rs2, rd, regwrite, memread, alusrc).
- One natural sub-module: fwd_sel, the combinational compare for a single operand, instantiated twice (A and B).

Test Plan:
- Reset: hold RST_N=0 mid-stream -> all forwards 00, PC_WRITE=1, HZ_STATE=00; after release the first ID instruction reaches EX next cycle.
- Back-to-back ALU dependency: add x5 then sub x6,x5,x7 -> second in EX gives FORWARD_A=10; with one unrelated instruction between -> FORWARD_A=01.
- Double match: x5 written in both MEM and WB -> FORWARD_A=10 (MEM wins); rd=x0 in MEM -> 00.
- Load-use: lw x5 followed by add x8,x5,x9 -> one cycle with PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1, HZ_STATE=01 the next cycle; add then enters EX with FORWARD_A=01.
- Branch plus load-use in the same cycle: BRANCH_TAKEN=1 with lu=1 -> IFID_FLUSH=1, IDEX_BUBBLE=1, PC_WRITE=1, HZ_STATE=10 next cycle.
- ALUSrc: addi x3,x1,4 in EX -> ALUSRC_EX=1 and FORWARD_B=00 even if rs2 field matches MEM.rd; with HAZARD_PERF_EN, 3 stalls and 2 flushes -> STALL_CNT=3, FLUSH_CNT=2.
